// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the general-purpose register file.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 3;

    typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
    typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// Combinational read port: address mux with optional write bypass.
module reg_file_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] regs [1<<ADDR_W],
    input  logic              hit,
    input  logic [DATA_W-1:0] byp_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = '0;
        if (rst) begin
            data = hit ? byp_data : regs[raddr];
        end
    end

endmodule

// File: rtl/reg_file.sv
// Register file: one synchronous write port, two combinational reads.
// Optional same-cycle write bypass with REGFILE_WR_BYPASS_EN.
module reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sto,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] databus1,
    output logic [DATA_W-1:0] databus2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              hit1;
    logic              hit2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (sto) begin
            regs[waddr] <= dataIn;
        end
    end

`ifdef REGFILE_WR_BYPASS_EN
    assign hit1 = sto && (waddr == raddr1);
    assign hit2 = sto && (waddr == raddr2);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd1 (
        .rst      (rst),
        .raddr    (raddr1),
        .regs     (regs),
        .hit      (hit1),
        .byp_data (dataIn),
        .data     (databus1)
    );

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd2 (
        .rst      (rst),
        .raddr    (raddr2),
        .regs     (regs),
        .hit      (hit2),
        .byp_data (dataIn),
        .data     (databus2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      sto;
    reg_addr_t waddr;
    reg_data_t dataIn;
    reg_addr_t raddr1;
    reg_addr_t raddr2;
    reg_data_t databus1;
    reg_data_t databus2;

    int checks = 0;
    int errors = 0;

    reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .sto      (sto),
        .waddr    (waddr),
        .dataIn   (dataIn),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .databus1 (databus1),
        .databus2 (databus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input reg_data_t obs, input reg_data_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input reg_addr_t a, input reg_data_t d);
        @(negedge clk);
        sto = 1'b1;
        waddr = a;
        dataIn = d;
        @(posedge clk);
        #1;
        sto = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        sto = 1'b0;
        waddr = '0;
        dataIn = '0;
        raddr1 = '0;
        raddr2 = '0;
        #1;
        chk("reset_bus1", databus1, 32'h0);
        chk("reset_bus2", databus2, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        wr(3'd0, 32'hABCD1234);
        raddr1 = 3'd0;
        raddr2 = 3'd0;
        #1;
        chk("r0_bus1", databus1, 32'hABCD1234);
        chk("r0_bus2", databus2, 32'hABCD1234);

        wr(3'd1, 32'hABCD1234);
        raddr1 = 3'd1;
        raddr2 = 3'd0;
        #1;
        chk("r1_bus1", databus1, 32'hABCD1234);
        chk("r1_bus2", databus2, 32'hABCD1234);

        @(negedge clk);
        sto = 1'b0;
        waddr = 3'd1;
        dataIn = 32'h0;
        @(posedge clk);
        #1;
        chk("r1_nowrite", databus1, 32'hABCD1234);

        for (int i = 0; i < 8; i++) begin
            wr(reg_addr_t'(i), 32'h1000_0000 + i);
        end
        for (int i = 0; i < 8; i++) begin
            raddr1 = reg_addr_t'(i);
            raddr2 = reg_addr_t'(7 - i);
            #1;
            chk($sformatf("sweep_bus1_%0d", i), databus1, 32'h1000_0000 + i);
            chk($sformatf("sweep_bus2_%0d", 7 - i), databus2, 32'h1000_0000 + 7 - i);
        end

        wr(3'd5, 32'h5);
        @(negedge clk);
        sto = 1'b1;
        waddr = 3'd5;
        dataIn = 32'hDEADBEEF;
        raddr1 = 3'd5;
        raddr2 = 3'd4;
        #1;
`ifdef REGFILE_WR_BYPASS_EN
        chk("rdw_before", databus1, 32'hDEADBEEF);
`else
        chk("rdw_before", databus1, 32'h5);
`endif
        chk("rdw_other_port", databus2, 32'h1000_0004);
        @(posedge clk);
        #1;
        sto = 1'b0;
        chk("rdw_after", databus1, 32'hDEADBEEF);

        @(negedge clk);
        sto = 1'b1;
        waddr = 3'd2;
        dataIn = 32'hFFFF_FFFF;
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            raddr1 = reg_addr_t'(i);
            raddr2 = reg_addr_t'(i);
            #1;
            chk($sformatf("async_rst_bus1_%0d", i), databus1, 32'h0);
            chk($sformatf("async_rst_bus2_%0d", i), databus2, 32'h0);
        end
        raddr1 = 3'd2;
        raddr2 = 3'd5;
        @(posedge clk);
        #1;
        chk("rst_edge_bus1", databus1, 32'h0);
        @(negedge clk);
        sto = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_no_write_r2", databus1, 32'h0);
        chk("rst_cleared_r5", databus2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
